demux_rr_ctrl: RTL and testbench

Round-robin burst scheduler for the 1-to-4 demux datapath. It accepts one input word stream with a valid/ready handshake and steers BURST words at a time to one of four destinations, d0..d3. It then rotates to the next enabled destination. Each destination can apply backpressure and can be masked out. The block generates the select lines the demux needs and gates the input handshake, so sharing of the demux between the four consumers is fully sequenced here.

---
 rtl/demux_ctrl_pkg.sv | 23 ++
 rtl/demux_rr_ctrl_if.sv | 21 ++
 rtl/rr_pick.sv | 24 ++
 rtl/demux_rr_ctrl.sv | 151 +++++++++++++++
 tb/tb_demux_rr_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the round-robin demux burst scheduler.
package demux_ctrl_pkg;

   localparam int NUM_PORTS = 4;
   localparam int SEL_W     = 2;
   localparam int CNT_W     = 8;
   localparam int STAT_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PICK = 2'd1,
      SEND = 2'd2
   } state_t;

   function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
      return p + SEL_W'(1);
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
      return (c == {STAT_W{1'b1}}) ? c : c + STAT_W'(1);
   endfunction

endpackage

// File: rtl/demux_rr_ctrl_if.sv
// Input stream plus the four destination channels of the 1-to-4 demux.
interface demux_rr_ctrl_if #(parameter int WIDTH = 8);

   logic [WIDTH-1:0] i;
   logic             i_valid;
   logic             i_ready;
   logic [WIDTH-1:0] d0, d1, d2, d3;
   logic             v0, v1, v2, v3;
   logic             r0, r1, r2, r3;

   modport master (
      input  i, i_valid, r0, r1, r2, r3,
      output i_ready, d0, d1, d2, d3, v0, v1, v2, v3
   );

   modport slave (
      output i, i_valid, r0, r1, r2, r3,
      input  i_ready, d0, d1, d2, d3, v0, v1, v2, v3
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible port at or above ptr, modulo 4.
module rr_pick
   import demux_ctrl_pkg::*;
(
   input  logic [NUM_PORTS-1:0] port_mask,
   input  logic [SEL_W-1:0]     ptr,
   output logic [SEL_W-1:0]     sel,
   output logic                 found
);

   logic [SEL_W-1:0] idx;

   // Scan downward in distance so the closest eligible port is written last.
   always_comb begin
      sel   = ptr;
      idx   = ptr;
      found = |port_mask;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = ptr + SEL_W'(k);
         sel = port_mask[idx] ? idx : sel;
      end
   end

endmodule

// File: rtl/demux_rr_ctrl.sv
// Round-robin burst scheduler driving the 1-to-4 demux select and handshakes.
// Optional per-port beat counters are enabled by defining DEMUX_CTRL_STATS_EN.
module demux_rr_ctrl
   import demux_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BURST = 4
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 e,
   input  logic [NUM_PORTS-1:0] port_mask,
   demux_rr_ctrl_if.master      bus,
   output logic                 s1,
   output logic                 s0,
   output logic                 busy
`ifdef DEMUX_CTRL_STATS_EN
   ,
   input  logic [SEL_W-1:0]     stat_sel,
   output logic [STAT_W-1:0]    stat_count
`endif
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

   state_t               state_r, state_nxt;
   logic [SEL_W-1:0]     ptr_r, ptr_nxt;
   logic [SEL_W-1:0]     sel_r, sel_nxt;
   logic [CNT_W-1:0]     count_r, count_nxt;
   logic [SEL_W-1:0]     pick_sel_s;
   logic                 pick_found_s;
   logic [NUM_PORTS-1:0] r_s;
   logic [NUM_PORTS-1:0] v_s;
   logic [WIDTH-1:0]     d_s [NUM_PORTS];
   logic                 i_ready_s;
   logic                 beat_s;

   rr_pick u_pick (
      .port_mask (port_mask),
      .ptr       (ptr_r),
      .sel       (pick_sel_s),
      .found     (pick_found_s)
   );

   assign r_s = {bus.r3, bus.r2, bus.r1, bus.r0};

   // Scheduler state, rotation pointer, select and beat count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r   <= SEL_W'(0);
         sel_r   <= SEL_W'(0);
         count_r <= CNT_W'(0);
      end else begin
         state_r <= state_nxt;
         ptr_r   <= ptr_nxt;
         sel_r   <= sel_nxt;
         count_r <= count_nxt;
      end
   end

   // Next-state logic and demux steering.
   always_comb begin
      state_nxt = state_r;
      ptr_nxt   = ptr_r;
      sel_nxt   = sel_r;
      count_nxt = count_r;
      i_ready_s = 1'b0;
      v_s       = '0;
      beat_s    = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         d_s[k] = '0;
      end
      case (state_r)
         IDLE: begin
            if (e && (port_mask != 4'b0000)) begin
               state_nxt = PICK;
            end else begin
               state_nxt = IDLE;
            end
         end
         PICK: begin
            if (e && pick_found_s) begin
               sel_nxt   = pick_sel_s;
               count_nxt = CNT_W'(0);
               state_nxt = SEND;
            end else begin
               state_nxt = IDLE;
            end
         end
         SEND: begin
            d_s[sel_r] = bus.i;
            // Losing enable parks in IDLE with ptr held, so the same port resumes.
            if (!e) begin
               state_nxt = IDLE;
            end else if (!port_mask[sel_r]) begin
               ptr_nxt   = next_port(sel_r);
               state_nxt = PICK;
            end else begin
               i_ready_s   = r_s[sel_r];
               v_s[sel_r]  = bus.i_valid;
               beat_s      = bus.i_valid & r_s[sel_r];
               if (beat_s && (count_r == LAST)) begin
                  ptr_nxt   = next_port(sel_r);
                  state_nxt = PICK;
               end else if (beat_s) begin
                  count_nxt = count_r + CNT_W'(1);
               end else begin
                  count_nxt = count_r;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.i_ready = i_ready_s;
   assign bus.d0      = d_s[0];
   assign bus.d1      = d_s[1];
   assign bus.d2      = d_s[2];
   assign bus.d3      = d_s[3];
   assign bus.v0      = v_s[0];
   assign bus.v1      = v_s[1];
   assign bus.v2      = v_s[2];
   assign bus.v3      = v_s[3];
   assign s1          = sel_r[1];
   assign s0          = sel_r[0];
   assign busy        = (state_r != IDLE);

`ifdef DEMUX_CTRL_STATS_EN
   logic [STAT_W-1:0] stat_r [NUM_PORTS];

   // Saturating beat counters, one per destination.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            stat_r[k] <= STAT_W'(0);
         end
      end else if (beat_s) begin
         stat_r[sel_r] <= sat_inc(stat_r[sel_r]);
      end else begin
         stat_r[sel_r] <= stat_r[sel_r];
      end
   end

   assign stat_count = stat_r[stat_sel];
`endif

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Scoreboard bench for demux_rr_ctrl: expected (port, word) pairs are queued up front
// and popped as beats appear on the destination side.
module tb_demux_rr_ctrl;
   import demux_ctrl_pkg::*;

   localparam int WIDTH = 8;
   localparam int BURST = 4;

   typedef struct {
      int               port;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       e = 1'b0;
   logic [3:0] port_mask = 4'b0000;
   logic       s1, s0, busy;
`ifdef DEMUX_CTRL_STATS_EN
   logic [1:0]  stat_sel = 2'd0;
   logic [15:0] stat_count;
`endif

   demux_rr_ctrl_if #(.WIDTH(WIDTH)) bus ();

   demux_rr_ctrl #(.WIDTH(WIDTH), .BURST(BURST)) dut (
      .clk       (clk),
      .rst       (rst),
      .e         (e),
      .port_mask (port_mask),
      .bus       (bus),
      .s1        (s1),
      .s0        (s0),
      .busy      (busy)
`ifdef DEMUX_CTRL_STATS_EN
      ,
      .stat_sel  (stat_sel),
      .stat_count(stat_count)
`endif
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   int   next_word = 1;
   bit   beat_seen = 1'b0;
   exp_t exp_q[$];

   task automatic push(input int port, input int first, input int last);
      for (int w = first; w <= last; w++) begin
         exp_q.push_back('{port, WIDTH'(w)});
      end
   endtask

   task automatic monitor();
      logic [3:0]       vv;
      logic [WIDTH-1:0] dd [4];
      int               hot;
      int               port;
      int               cur;
      bit               quiet;
      exp_t             x;
      vv    = {bus.v3, bus.v2, bus.v1, bus.v0};
      dd[0] = bus.d0; dd[1] = bus.d1; dd[2] = bus.d2; dd[3] = bus.d3;
      cur   = int'({s1, s0});
      quiet = 1'b1;
      for (int p = 0; p < 4; p++) begin
         if (p != cur && (vv[p] !== 1'b0 || dd[p] !== '0)) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin
         bad++;
         $display("FAIL quiet_ports: v=%b d=%h/%h/%h/%h sel=%0d want unselected ports 0",
                  vv, dd[3], dd[2], dd[1], dd[0], cur);
      end
      beat_seen = bus.i_valid && bus.i_ready;
      if (beat_seen) begin
         hot  = 0;
         port = -1;
         for (int p = 0; p < 4; p++) begin
            if (vv[p] === 1'b1) begin
               hot++;
               port = p;
            end
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: port=%0d data=%h want no beat", port, bus.i);
         end else begin
            x = exp_q.pop_front();
            if (hot != 1 || port !== x.port || dd[x.port] !== x.data) begin
               bad++;
               $display("FAIL beat: port=%0d data=%h v=%b want port=%0d data=%h",
                        port, (port >= 0) ? dd[port] : bus.i, vv, x.port, x.data);
            end
         end
      end
   endtask

   task automatic finish_cycle();
      monitor();
      @(posedge clk);
      #1;
      if (beat_seen) next_word++;
      bus.i = WIDTH'(next_word);
   endtask

   task automatic tick();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic run_until(input int budget, output int used);
      used = 0;
      while (exp_q.size() != 0 && used < budget) begin
         tick();
         used++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL timeout: %0d words still pending after %0d cycles want 0", exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      e           = 1'b0;
      port_mask   = 4'b0000;
      bus.i_valid = 1'b0;
      bus.r0 = 1'b1; bus.r1 = 1'b1; bus.r2 = 1'b1; bus.r3 = 1'b1;
      next_word   = 1;
      bus.i       = WIDTH'(1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_valid = 1'b1;
      bus.r0 = 1'b1; bus.r1 = 1'b1; bus.r2 = 1'b1; bus.r3 = 1'b1;
      bus.i = 8'hA5;
      @(negedge clk);
      total++;
      if ({s1, s0, busy, bus.i_ready, bus.v3, bus.v2, bus.v1, bus.v0} !== 8'h00 ||
          {bus.d3, bus.d2, bus.d1, bus.d0} !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: s=%b%b busy=%b rdy=%b v=%b%b%b%b d=%h%h%h%h want all 0",
                  s1, s0, busy, bus.i_ready, bus.v3, bus.v2, bus.v1, bus.v0,
                  bus.d3, bus.d2, bus.d1, bus.d0);
      end
      do_reset();
      repeat (2) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || bus.i_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_disabled: busy=%b rdy=%b want 0 0", busy, bus.i_ready);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_rotate_all();
      int used;
      do_reset();
      port_mask = 4'b1111; e = 1'b1; bus.i_valid = 1'b1;
      push(0, 1, 4); push(1, 5, 8); push(2, 9, 12); push(3, 13, 16);
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL latency_idle: busy=%b want 0", busy);
      end
      finish_cycle();
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || bus.i_ready !== 1'b0) begin
         bad++;
         $display("FAIL latency_pick: busy=%b rdy=%b want 1 0", busy, bus.i_ready);
      end
      finish_cycle();
      run_until(40, used);
      total++;
      if (used != 19) begin
         bad++;
         $display("FAIL bubble_cycles: took %0d cycles want 19", used);
      end
`ifdef DEMUX_CTRL_STATS_EN
      for (int p = 0; p < 4; p++) begin
         stat_sel = 2'(p);
         #1;
         total++;
         if (stat_count !== 16'd4) begin
            bad++;
            $display("FAIL stat_after_rotate: port=%0d got %0d want 4", p, stat_count);
         end
      end
`endif
      e = 1'b0;
   endtask

   task automatic test_masked();
      int used;
      do_reset();
      port_mask = 4'b0101; e = 1'b1; bus.i_valid = 1'b1;
      push(0, 1, 4); push(2, 5, 8); push(0, 9, 12);
      run_until(40, used);
      e = 1'b0;
   endtask

   task automatic test_backpressure();
      int used;
      do_reset();
      port_mask = 4'b1111; e = 1'b1; bus.i_valid = 1'b1;
      push(0, 1, 4); push(1, 5, 6);
      run_until(30, used);
      bus.r1 = 1'b0;
      repeat (5) begin
         @(negedge clk);
         total++;
         if (bus.i_ready !== 1'b0 || {s1, s0} !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_hold: rdy=%b s=%b%b busy=%b want 0 01 1",
                     bus.i_ready, s1, s0, busy);
         end
         finish_cycle();
      end
      bus.r1 = 1'b1;
      push(1, 7, 8); push(2, 9, 12);
      run_until(30, used);
      e = 1'b0;
   endtask

   task automatic test_enable_drop();
      int used;
      do_reset();
      port_mask = 4'b1111; e = 1'b1; bus.i_valid = 1'b1;
      push(0, 1, 2);
      run_until(30, used);
      e = 1'b0;
      repeat (3) begin
         @(negedge clk);
         total++;
         if (bus.i_ready !== 1'b0 || bus.v0 !== 1'b0) begin
            bad++;
            $display("FAIL enable_low: rdy=%b v0=%b want 0 0", bus.i_ready, bus.v0);
         end
         finish_cycle();
      end
      e = 1'b1;
      push(0, 3, 6); push(1, 7, 8);
      run_until(30, used);
      e = 1'b0;
   endtask

   task automatic test_mask_clear_and_reset();
      int used;
      do_reset();
      port_mask = 4'b1111; e = 1'b1; bus.i_valid = 1'b1;
      push(0, 1, 4); push(1, 5, 5);
      run_until(30, used);
      port_mask = 4'b1101;
      @(negedge clk);
      total++;
      if (bus.i_ready !== 1'b0 || bus.v1 !== 1'b0) begin
         bad++;
         $display("FAIL mask_clear_cycle: rdy=%b v1=%b want 0 0", bus.i_ready, bus.v1);
      end
      finish_cycle();
      push(2, 6, 9);
      run_until(30, used);
      push(3, 10, 11);
      run_until(30, used);
      rst = 1'b1;
      #1;
      total++;
      if ({s1, s0, busy, bus.i_ready, bus.v3, bus.v2, bus.v1, bus.v0} !== 8'h00 ||
          {bus.d3, bus.d2, bus.d1, bus.d0} !== 32'h0) begin
         bad++;
         $display("FAIL midburst_reset: s=%b%b busy=%b rdy=%b v=%b%b%b%b want all 0",
                  s1, s0, busy, bus.i_ready, bus.v3, bus.v2, bus.v1, bus.v0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push(0, 12, 15);
      run_until(30, used);
      e = 1'b0;
   endtask

`ifdef DEMUX_CTRL_STATS_EN
   task automatic test_stats_saturate();
      int used;
      do_reset();
      port_mask = 4'b0001; e = 1'b1; bus.i_valid = 1'b1;
      push(0, 1, 65540);
      run_until(90000, used);
      e = 1'b0;
      stat_sel = 2'd0;
      #1;
      total++;
      if (stat_count !== 16'hFFFF) begin
         bad++;
         $display("FAIL stat_saturate: got %h want ffff", stat_count);
      end
      stat_sel = 2'd1;
      #1;
      total++;
      if (stat_count !== 16'h0000) begin
         bad++;
         $display("FAIL stat_other_port: got %h want 0000", stat_count);
      end
   endtask
`endif

   initial begin
      bus.i = '0;
      bus.i_valid = 1'b0;
      bus.r0 = 1'b1; bus.r1 = 1'b1; bus.r2 = 1'b1; bus.r3 = 1'b1;
      test_reset();
      test_rotate_all();
      test_masked();
      test_backpressure();
      test_enable_drop();
      test_mask_clear_and_reset();
`ifdef DEMUX_CTRL_STATS_EN
      test_stats_saturate();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
